// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction-fetch (IF)
// and data-access (DM) requesters. One command in flight at a time; a command is
// issued combinationally in IDLE or RESP, waits MEM_LAT cycles, then the owner's
// valid pulses for one cycle in RESP.
// Optional build macro ARB_RR_EN: round-robin arbitration instead of fixed DM priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic              o_if_gnt,
  output logic              o_if_valid,
  output logic [31:0]       o_if_data,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [DATA_W-1:0] i_dm_wdata,
  output logic              o_dm_gnt,
  output logic              o_dm_valid,
  output logic [DATA_W-1:0] o_dm_rdata,
  output logic              o_mem_cs,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_owner_dm;
  logic               r_we;
  logic [31:0]        r_if_data;
  logic [DATA_W-1:0]  r_dm_rdata;

  logic               w_arb;
  logic               w_pick_dm;
  logic               w_pick_if;
  logic               w_gnt_dm;
  logic               w_gnt_if;
  logic               w_issue;
  logic               w_last;

  // Arbitration is open in IDLE and RESP; held off while reset is asserted so every
  // output reads 0 during reset even if requests are still up.
  assign w_arb = (r_state != ST_WAIT) && !i_rst;

`ifdef ARB_RR_EN
  // Priority pointer: 1 = DM wins the next simultaneous request.
  logic r_rr_dm;

  // Pointer moves to the other requester on every grant.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rr_dm <= 1'b1;
    end else if (w_issue) begin
      r_rr_dm <= w_gnt_if;
    end
  end

  assign w_pick_dm = i_dm_req && (!i_if_req || r_rr_dm);
`else
  // MEM stage is older in the pipeline, so it always beats fetch.
  assign w_pick_dm = i_dm_req;
`endif

  assign w_pick_if = i_if_req && !w_pick_dm;
  assign w_gnt_dm  = w_arb && w_pick_dm;
  assign w_gnt_if  = w_arb && w_pick_if;
  assign w_issue   = w_gnt_dm || w_gnt_if;
  assign w_last    = (r_cnt == '0);

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state: issue from IDLE/RESP, count down in WAIT.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_next = ST_WAIT;
      ST_WAIT: if (w_last) w_next = ST_RESP;
      ST_RESP: w_next = w_issue ? ST_WAIT : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs: grant and memory command are combinational from the winning request.
  always_comb begin
    o_if_gnt    = w_gnt_if;
    o_dm_gnt    = w_gnt_dm;
    o_mem_cs    = w_issue;
    o_mem_we    = w_gnt_dm && i_dm_we;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt_dm) begin
      o_mem_addr = i_dm_addr >> 2;
      if (i_dm_we) begin
        o_mem_wdata = i_dm_wdata;
      end
    end else if (w_gnt_if) begin
      o_mem_addr = i_if_addr >> 2;
    end
    o_if_valid = (r_state == ST_RESP) && !r_owner_dm;
    o_dm_valid = (r_state == ST_RESP) && r_owner_dm;
    o_if_data  = r_if_data;
    o_dm_rdata = r_dm_rdata;
  end

  // Transaction bookkeeping: latch owner/op at issue, capture read data on last WAIT cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_if_data  <= '0;
      r_dm_rdata <= '0;
    end else if (w_issue) begin
      r_cnt      <= CNT_W'(MEM_LAT - 1);
      r_owner_dm <= w_gnt_dm;
      r_we       <= w_gnt_dm && i_dm_we;
    end else if (r_state == ST_WAIT) begin
      if (w_last) begin
        if (r_owner_dm) begin
          r_dm_rdata <= r_we ? '0 : i_mem_rdata;
        end else begin
          r_if_data <= i_mem_rdata[31:0];
        end
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with MEM_LAT=1 (a_*) and one with
// MEM_LAT=3 (b_*) share all inputs. Inputs change 1 time unit after the rising edge,
// outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] mem_rdata;

  logic        a_if_gnt, a_if_valid, a_dm_gnt, a_dm_valid, a_mem_cs, a_mem_we;
  logic [31:0] a_if_data;
  logic [63:0] a_dm_rdata, a_mem_addr, a_mem_wdata;
  logic        b_if_gnt, b_if_valid, b_dm_gnt, b_dm_valid, b_mem_cs, b_mem_we;
  logic [31:0] b_if_data;
  logic [63:0] b_dm_rdata, b_mem_addr, b_mem_wdata;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(a_if_gnt), .o_if_valid(a_if_valid), .o_if_data(a_if_data),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_gnt(a_dm_gnt), .o_dm_valid(a_dm_valid), .o_dm_rdata(a_dm_rdata),
    .o_mem_cs(a_mem_cs), .o_mem_we(a_mem_we), .o_mem_addr(a_mem_addr),
    .o_mem_wdata(a_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst(rst),
    .i_if_req(if_req), .i_if_addr(if_addr),
    .o_if_gnt(b_if_gnt), .o_if_valid(b_if_valid), .o_if_data(b_if_data),
    .i_dm_req(dm_req), .i_dm_we(dm_we), .i_dm_addr(dm_addr), .i_dm_wdata(dm_wdata),
    .o_dm_gnt(b_dm_gnt), .o_dm_valid(b_dm_valid), .o_dm_rdata(b_dm_rdata),
    .o_mem_cs(b_mem_cs), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr),
    .o_mem_wdata(b_mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic pulse_rst();
    tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    smp();
    checks++; if ({a_if_gnt, a_dm_gnt, a_if_valid, a_dm_valid, a_mem_cs, a_mem_we} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {a_if_gnt, a_dm_gnt, a_if_valid, a_dm_valid, a_mem_cs, a_mem_we}); end
    checks++; if (a_mem_addr !== 64'h0 || a_mem_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h expected 0", a_mem_addr, a_mem_wdata); end
    checks++; if (a_if_data !== 32'h0 || a_dm_rdata !== 64'h0) begin
      errors++; $display("FAIL reset_data: got if %h dm %h expected 0", a_if_data, a_dm_rdata); end
    // bring u_lat1 into RESP with a fetch, then assert reset mid-cycle
    tick(); if_req = 1'b1; if_addr = 64'h10;
    tick(); if_req = 1'b0; mem_rdata = 64'h99;
    tick(); mem_rdata = 64'h0;
    smp();
    checks++; if (a_if_valid !== 1'b1) begin
      errors++; $display("FAIL reset_pre_valid: got %b expected 1", a_if_valid); end
    #1 rst = 1'b1;
    #1;
    checks++; if (a_if_valid !== 1'b0 || a_if_data !== 32'h0) begin
      errors++; $display("FAIL reset_async: got valid %b data %h expected 0 0", a_if_valid, a_if_data); end
    if_req = 1'b1; if_addr = 64'h20;
    #1;
    checks++; if (a_if_gnt !== 1'b0 || a_mem_cs !== 1'b0) begin
      errors++; $display("FAIL reset_gnt_held: got gnt %b cs %b expected 0 0", a_if_gnt, a_mem_cs); end
    if_req = 1'b0;
    #1 rst = 1'b0;
  endtask

  task automatic test_if_fetch();
    tick(); if_req = 1'b1; if_addr = 64'h10;
    smp();
    checks++; if (a_if_gnt !== 1'b1 || a_mem_cs !== 1'b1 || a_mem_we !== 1'b0 || a_dm_gnt !== 1'b0) begin
      errors++; $display("FAIL fetch_issue: got gnt %b cs %b we %b dm_gnt %b expected 1 1 0 0",
        a_if_gnt, a_mem_cs, a_mem_we, a_dm_gnt); end
    checks++; if (a_mem_addr !== 64'h4) begin
      errors++; $display("FAIL fetch_addr: got %h expected 4", a_mem_addr); end
    tick(); if_req = 1'b0; mem_rdata = 64'h13;
    smp();
    checks++; if (a_if_valid !== 1'b0 || a_mem_cs !== 1'b0) begin
      errors++; $display("FAIL fetch_wait: got valid %b cs %b expected 0 0", a_if_valid, a_mem_cs); end
    tick(); mem_rdata = 64'h0;
    smp();
    checks++; if (a_if_valid !== 1'b1 || a_if_data !== 32'h00000013) begin
      errors++; $display("FAIL fetch_resp: got valid %b data %h expected 1 00000013", a_if_valid, a_if_data); end
    tick();
    smp();
    checks++; if (a_if_valid !== 1'b0) begin
      errors++; $display("FAIL fetch_pulse: got valid %b expected 0", a_if_valid); end
  endtask

  task automatic test_arbitration();
    tick(); if_req = 1'b1; if_addr = 64'h8; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h20;
    smp();
    checks++; if (a_dm_gnt !== 1'b1 || a_if_gnt !== 1'b0 || a_mem_addr !== 64'h8) begin
      errors++; $display("FAIL arb_first: got dm %b if %b addr %h expected 1 0 8", a_dm_gnt, a_if_gnt, a_mem_addr); end
    tick(); dm_req = 1'b0; mem_rdata = 64'hA5A5;
    smp();
    checks++; if (a_if_gnt !== 1'b0 || a_dm_gnt !== 1'b0 || a_mem_cs !== 1'b0) begin
      errors++; $display("FAIL arb_wait_no_gnt: got if %b dm %b cs %b expected 0 0 0", a_if_gnt, a_dm_gnt, a_mem_cs); end
    tick(); mem_rdata = 64'h0;
    smp();
    checks++; if (a_dm_valid !== 1'b1 || a_dm_rdata !== 64'hA5A5) begin
      errors++; $display("FAIL arb_dm_resp: got valid %b data %h expected 1 a5a5", a_dm_valid, a_dm_rdata); end
    checks++; if (a_if_gnt !== 1'b1 || a_mem_addr !== 64'h2) begin
      errors++; $display("FAIL arb_if_in_resp: got gnt %b addr %h expected 1 2", a_if_gnt, a_mem_addr); end
    tick(); if_req = 1'b0; mem_rdata = 64'h77;
    smp();
    checks++; if (a_if_gnt !== 1'b0 || a_dm_valid !== 1'b0) begin
      errors++; $display("FAIL arb_if_wait: got gnt %b dm_valid %b expected 0 0", a_if_gnt, a_dm_valid); end
    tick(); mem_rdata = 64'h0;
    smp();
    checks++; if (a_if_valid !== 1'b1 || a_if_data !== 32'h77 || a_dm_valid !== 1'b0) begin
      errors++; $display("FAIL arb_if_resp: got valid %b data %h dm_valid %b expected 1 77 0",
        a_if_valid, a_if_data, a_dm_valid); end
    tick();
  endtask

  task automatic test_store();
    tick(); dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h40; dm_wdata = 64'hDEAD;
    smp();
    checks++; if (a_dm_gnt !== 1'b1 || a_mem_cs !== 1'b1 || a_mem_we !== 1'b1) begin
      errors++; $display("FAIL store_issue: got gnt %b cs %b we %b expected 1 1 1", a_dm_gnt, a_mem_cs, a_mem_we); end
    checks++; if (a_mem_addr !== 64'h10 || a_mem_wdata !== 64'hDEAD) begin
      errors++; $display("FAIL store_bus: got addr %h wdata %h expected 10 dead", a_mem_addr, a_mem_wdata); end
    tick(); dm_req = 1'b0; dm_we = 1'b0; mem_rdata = 64'hFFFF;
    smp();
    checks++; if (a_mem_we !== 1'b0 || a_mem_wdata !== 64'h0 || a_mem_addr !== 64'h0) begin
      errors++; $display("FAIL store_idle_bus: got we %b wdata %h addr %h expected 0 0 0", a_mem_we, a_mem_wdata, a_mem_addr); end
    tick(); mem_rdata = 64'h0;
    smp();
    checks++; if (a_dm_valid !== 1'b1 || a_dm_rdata !== 64'h0) begin
      errors++; $display("FAIL store_ack: got valid %b rdata %h expected 1 0", a_dm_valid, a_dm_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    pulse_rst();
    if_req = 1'b1; if_addr = 64'h100;
    smp();
    checks++; if (b_if_gnt !== 1'b1 || b_mem_cs !== 1'b1 || b_mem_addr !== 64'h40) begin
      errors++; $display("FAIL lat3_issue: got gnt %b cs %b addr %h expected 1 1 40", b_if_gnt, b_mem_cs, b_mem_addr); end
    tick(); if_req = 1'b0; mem_rdata = 64'h1234;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (b_if_valid !== 1'b0 || b_mem_cs !== 1'b0 || b_if_gnt !== 1'b0) begin
      errors++; $display("FAIL lat3_reset: got valid %b cs %b gnt %b expected 0 0 0", b_if_valid, b_mem_cs, b_if_gnt); end
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      smp();
      checks++; if (b_if_valid !== 1'b0 || b_dm_valid !== 1'b0) begin
        errors++; $display("FAIL lat3_no_valid[%0d]: got if %b dm %b expected 0 0", i, b_if_valid, b_dm_valid); end
    end
    mem_rdata = 64'h0;
    tick(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h8;
    smp();
    checks++; if (b_dm_gnt !== 1'b1 || b_mem_addr !== 64'h2) begin
      errors++; $display("FAIL lat3_reissue: got gnt %b addr %h expected 1 2", b_dm_gnt, b_mem_addr); end
    tick(); dm_req = 1'b0;
    tick();
    smp();
    checks++; if (b_dm_valid !== 1'b0) begin
      errors++; $display("FAIL lat3_early: got valid %b expected 0", b_dm_valid); end
    tick(); mem_rdata = 64'h55;
    tick(); mem_rdata = 64'h0;
    smp();
    checks++; if (b_dm_valid !== 1'b1 || b_dm_rdata !== 64'h55) begin
      errors++; $display("FAIL lat3_resp: got valid %b data %h expected 1 55", b_dm_valid, b_dm_rdata); end
    tick();
    smp();
    checks++; if (b_dm_valid !== 1'b0) begin
      errors++; $display("FAIL lat3_pulse: got valid %b expected 0", b_dm_valid); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_dm;
    logic [3:0] exp_if;
`ifdef ARB_RR_EN
    exp_dm = 4'b0101;
    exp_if = 4'b1010;
`else
    exp_dm = 4'b1111;
    exp_if = 4'b0000;
`endif
    pulse_rst();
    if_req = 1'b1; if_addr = 64'h30; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h50;
    for (int k = 0; k < 4; k++) begin
      smp();
      checks++; if (a_dm_gnt !== exp_dm[k] || a_if_gnt !== exp_if[k]) begin
        errors++; $display("FAIL b2b_grant[%0d]: got dm %b if %b expected %b %b",
          k, a_dm_gnt, a_if_gnt, exp_dm[k], exp_if[k]); end
      tick();
      smp();
      checks++; if (a_dm_gnt !== 1'b0 || a_if_gnt !== 1'b0) begin
        errors++; $display("FAIL b2b_wait[%0d]: got dm %b if %b expected 0 0", k, a_dm_gnt, a_if_gnt); end
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0;
    #12 rst = 1'b0;
    test_reset();
    test_if_fetch();
    test_arbitration();
    test_store();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
